// File: rtl/exec_pkg.sv
// Shared encodings for the RV32IM execute stage: ALU/M-extension op codes, forwarding selects,
// EX/MEM control bit positions and divider FSM states.
package exec_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9
  } alu_op_e;

  // funct3 order
  typedef enum logic [2:0] {
    MdMul    = 3'd0,
    MdMulh   = 3'd1,
    MdMulhsu = 3'd2,
    MdMulhu  = 3'd3,
    MdDiv    = 3'd4,
    MdDivu   = 3'd5,
    MdRem    = 3'd6,
    MdRemu   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    FwdReg = 2'b00,
    FwdWb  = 2'b01,
    FwdMem = 2'b10
  } fwd_sel_e;

  localparam int unsigned CtlWidth    = 5;
  localparam int unsigned CtlBranch   = 0;
  localparam int unsigned CtlMemWrite = 1;
  localparam int unsigned CtlMemRead  = 2;
  localparam int unsigned CtlRegWrite = 3;
  localparam int unsigned CtlMemtoReg = 4;

  typedef enum logic [1:0] {
    DivIdle = 2'b00,
    DivRun  = 2'b01,
    DivDone = 2'b10
  } div_state_e;

  function automatic logic md_is_div(logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic md_is_signed_div(logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic md_is_rem(logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/exec_muldiv.sv
// M-extension unit: single-cycle multiplier plus an iterative restoring divider that retires
// DIV_STEP quotient bits per cycle. Only instantiated when EXEC_MULDIV_EN is defined.
module exec_muldiv
  import exec_pkg::*;
#(
  parameter int unsigned DIV_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [2:0]  md_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned RunCycles = 32 / DIV_STEP;

  // Multiplier: 33-bit sign/zero extension covers all four signedness combinations.
  logic               mul_a_signed, mul_b_signed;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] product;
  logic [31:0]        mul_result;

  assign mul_a_signed = (md_op != MdMulhu);
  assign mul_b_signed = (md_op == MdMul) || (md_op == MdMulh);
  assign mul_a        = {mul_a_signed & op_a[31], op_a};
  assign mul_b        = {mul_b_signed & op_b[31], op_b};
  assign product      = mul_a * mul_b;
  assign mul_result   = (md_op == MdMul) ? product[31:0] : product[63:32];

  // Divider operates on magnitudes; signs are reapplied when the result is read out.
  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic        quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
  logic        dvs_zero_q, dvs_zero_d, is_rem_q, is_rem_d;

  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;

  assign a_neg = md_is_signed_div(md_op) & op_a[31];
  assign b_neg = md_is_signed_div(md_op) & op_b[31];
  assign a_abs = a_neg ? (32'd0 - op_a) : op_a;
  assign b_abs = b_neg ? (32'd0 - op_b) : op_b;

  logic [31:0] step_quo, step_rem;
  logic [33:0] trial;

  always_comb begin
    step_quo = quo_q;
    step_rem = rem_q;
    trial    = '0;
    for (int unsigned i = 0; i < DIV_STEP; i++) begin
      trial = {1'b0, step_rem, step_quo[31]} - {2'b00, dvs_q};
      if (!trial[33]) begin
        step_rem = trial[31:0];
        step_quo = {step_quo[30:0], 1'b1};
      end else begin
        step_rem = {step_rem[30:0], step_quo[31]};
        step_quo = {step_quo[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    dvs_zero_d = dvs_zero_q;
    is_rem_d   = is_rem_q;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      DivIdle: begin
        if (start && !flush) begin
          busy       = 1'b1;
          state_d    = DivRun;
          cnt_d      = 5'(RunCycles - 1);
          quo_d      = a_abs;
          rem_d      = '0;
          dvs_d      = b_abs;
          quo_neg_d  = a_neg ^ b_neg;
          rem_neg_d  = a_neg;
          dvs_zero_d = (op_b == '0);
          is_rem_d   = md_is_rem(md_op);
        end
      end
      DivRun: begin
        if (flush) begin
          state_d = DivIdle;
        end else begin
          busy  = 1'b1;
          quo_d = step_quo;
          rem_d = step_rem;
          if (cnt_q == '0) begin
            state_d = DivDone;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      DivDone: begin
        done    = ~flush;
        state_d = DivIdle;
      end
      default: state_d = DivIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= DivIdle;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      dvs_zero_q <= 1'b0;
      is_rem_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
      dvs_zero_q <= dvs_zero_d;
      is_rem_q   <= is_rem_d;
    end
  end

  // A zero divisor leaves the magnitude of the dividend in rem_q, so only the quotient needs fixing.
  logic [31:0] div_quo, div_rem;

  assign div_quo = dvs_zero_q ? 32'hFFFF_FFFF : (quo_neg_q ? (32'd0 - quo_q) : quo_q);
  assign div_rem = rem_neg_q ? (32'd0 - rem_q) : rem_q;
  assign result  = md_is_div(md_op) ? (is_rem_q ? div_rem : div_quo) : mul_result;

  logic unused_trial;
  assign unused_trial = trial[32];

endmodule

// File: rtl/execute_stage.sv
// RV32IM execute stage with EX/MEM pipeline register. Define EXEC_MULDIV_EN to build the
// M-extension unit; otherwise md_valid is ignored and ex_stall is tied low.
module execute_stage
  import exec_pkg::*;
#(
  parameter int unsigned DIV_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ctl_in,
  input  logic        jal_in,
  input  logic        jalr_in,
  input  logic        bne_in,
  input  logic [3:0]  alu_op,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic        alu_src,
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [31:0] pc_in,
  input  logic [31:0] wb_data,
  input  logic [31:0] mem_alu,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        ex_stall,
  output logic [4:0]  ctl_out,
  output logic        jal_out,
  output logic        jalr_out,
  output logic        bne_out,
  output logic        zero_out,
  output logic [31:0] alu_result,
  output logic [31:0] write_data,
  output logic [31:0] pcimm_out,
  output logic [31:0] pc_out,
  output logic [4:0]  rd_out
);

  logic [31:0] op_a, rs2_fwd, op_b;

  always_comb begin
    case (fwd_a)
      FwdWb:   op_a = wb_data;
      FwdMem:  op_a = mem_alu;
      default: op_a = rs1_data;
    endcase
    case (fwd_b)
      FwdWb:   rs2_fwd = wb_data;
      FwdMem:  rs2_fwd = mem_alu;
      default: rs2_fwd = rs2_data;
    endcase
  end

  assign op_b = alu_src ? imm : rs2_fwd;

  logic [31:0] alu_res;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      AluAdd:  alu_res = op_a + op_b;
      AluSub:  alu_res = op_a - op_b;
      AluAnd:  alu_res = op_a & op_b;
      AluOr:   alu_res = op_a | op_b;
      AluXor:  alu_res = op_a ^ op_b;
      AluSll:  alu_res = op_a << op_b[4:0];
      AluSrl:  alu_res = op_a >> op_b[4:0];
      AluSra:  alu_res = $signed(op_a) >>> op_b[4:0];
      AluSlt:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      AluSltu: alu_res = {31'd0, op_a < op_b};
      default: alu_res = '0;
    endcase
  end

  logic [31:0] ex_result;

`ifdef EXEC_MULDIV_EN
  logic [31:0] md_result;
  logic        md_done;

  exec_muldiv #(
    .DIV_STEP(DIV_STEP)
  ) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (md_valid & md_is_div(md_op)),
    .flush (flush),
    .md_op (md_op),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (ex_stall),
    .done  (md_done),
    .result(md_result)
  );

  // While a divide is still running the stage latches a bubble, so md_result is only
  // architecturally visible in the DONE cycle.
  assign ex_result = md_valid ? md_result : alu_res;

  logic unused_done;
  assign unused_done = md_done;
`else
  assign ex_result = alu_res;
  assign ex_stall  = 1'b0;

  logic unused_md;
  assign unused_md = ^{md_valid, md_op, DIV_STEP[0]};
`endif

  logic bubble;
  assign bubble = flush | ex_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_out    <= '0;
      jal_out    <= 1'b0;
      jalr_out   <= 1'b0;
      bne_out    <= 1'b0;
      zero_out   <= 1'b0;
      alu_result <= '0;
      write_data <= '0;
      pcimm_out  <= '0;
      pc_out     <= '0;
      rd_out     <= '0;
    end else begin
      ctl_out    <= bubble ? '0 : ctl_in;
      jal_out    <= ~bubble & jal_in;
      jalr_out   <= ~bubble & jalr_in;
      bne_out    <= ~bubble & bne_in;
      rd_out     <= bubble ? '0 : rd_in;
      zero_out   <= (ex_result == '0);
      alu_result <= ex_result;
      write_data <= rs2_fwd;
      pcimm_out  <= pc_in + imm;
      pc_out     <= pc_in;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage; M-extension cases run when EXEC_MULDIV_EN is defined.
module tb_execute_stage;

  localparam int unsigned DivStep   = 1;
  localparam int unsigned DivCycles = 32 / DivStep + 1;
`ifdef EXEC_MULDIV_EN
  localparam bit MdEn = 1'b1;
`else
  localparam bit MdEn = 1'b0;
`endif

  logic        clk, reset;
  logic [4:0]  ctl_in;
  logic        jal_in, jalr_in, bne_in;
  logic [3:0]  alu_op;
  logic        md_valid;
  logic [2:0]  md_op;
  logic        alu_src;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] rs1_data, rs2_data, imm, pc_in, wb_data, mem_alu;
  logic [4:0]  rd_in;
  logic        flush;
  logic        ex_stall;
  logic [4:0]  ctl_out;
  logic        jal_out, jalr_out, bne_out, zero_out;
  logic [31:0] alu_result, write_data, pcimm_out, pc_out;
  logic [4:0]  rd_out;

  execute_stage #(
    .DIV_STEP(DivStep)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ctl_in    (ctl_in),
    .jal_in    (jal_in),
    .jalr_in   (jalr_in),
    .bne_in    (bne_in),
    .alu_op    (alu_op),
    .md_valid  (md_valid),
    .md_op     (md_op),
    .alu_src   (alu_src),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .imm       (imm),
    .pc_in     (pc_in),
    .wb_data   (wb_data),
    .mem_alu   (mem_alu),
    .rd_in     (rd_in),
    .flush     (flush),
    .ex_stall  (ex_stall),
    .ctl_out   (ctl_out),
    .jal_out   (jal_out),
    .jalr_out  (jalr_out),
    .bne_out   (bne_out),
    .zero_out  (zero_out),
    .alu_result(alu_result),
    .write_data(write_data),
    .pcimm_out (pcimm_out),
    .pc_out    (pc_out),
    .rd_out    (rd_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  ctl;
    logic        jal, jalr, bne;
    logic [3:0]  alu_op;
    logic        md_valid;
    logic [2:0]  md_op;
    logic        alu_src;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] rs1, rs2, imm, pc, wb, mem;
    logic [4:0]  rd;
    logic        flush;
  } stim_t;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic [4:0]  ctl;
    logic [2:0]  jmp;
    logic [4:0]  rd;
    logic [31:0] wdata, pcimm, pc;
    int          stalls;
    logic        data_valid;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd_pick(input logic [1:0] f, input logic [31:0] r,
                                           input logic [31:0] wb, input logic [31:0] mem);
    if (f == 2'b01) return wb;
    if (f == 2'b10) return mem;
    return r;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return 32'($signed(a) >>> b[4:0]);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, t;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: t = sa * sb;
      3'd1: t = (sa * sb) >>> 32;
      3'd2: t = (sa * ub) >>> 32;
      3'd3: t = (ua * ub) >> 32;
      3'd4: t = (b == 0) ? -64'sd1 : sa / sb;
      3'd5: t = (b == 0) ? -64'sd1 : ua / ub;
      3'd6: t = (b == 0) ? sa : sa % sb;
      default: t = (b == 0) ? ua : ua % ub;
    endcase
    return t[31:0];
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t        e;
    logic [31:0] a, b2, b;
    a  = fwd_pick(s.fwd_a, s.rs1, s.wb, s.mem);
    b2 = fwd_pick(s.fwd_b, s.rs2, s.wb, s.mem);
    b  = s.alu_src ? s.imm : b2;
    e.res        = (MdEn && s.md_valid) ? ref_md(s.md_op, a, b) : ref_alu(s.alu_op, a, b);
    e.zero       = (e.res == 32'd0);
    e.ctl        = s.flush ? 5'd0 : s.ctl;
    e.jmp        = s.flush ? 3'd0 : {s.jal, s.jalr, s.bne};
    e.rd         = s.flush ? 5'd0 : s.rd;
    e.wdata      = b2;
    e.pcimm      = s.pc + s.imm;
    e.pc         = s.pc;
    e.stalls     = (MdEn && s.md_valid && s.md_op[2] && !s.flush) ? DivCycles : 0;
    e.data_valid = !s.flush;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    ctl_in   = s.ctl;
    jal_in   = s.jal;
    jalr_in  = s.jalr;
    bne_in   = s.bne;
    alu_op   = s.alu_op;
    md_valid = s.md_valid;
    md_op    = s.md_op;
    alu_src  = s.alu_src;
    fwd_a    = s.fwd_a;
    fwd_b    = s.fwd_b;
    rs1_data = s.rs1;
    rs2_data = s.rs2;
    imm      = s.imm;
    pc_in    = s.pc;
    wb_data  = s.wb;
    mem_alu  = s.mem;
    rd_in    = s.rd;
    flush    = s.flush;
  endtask

  function automatic stim_t base(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    stim_t s;
    s = '{ctl: 5'b01000, jal: 1'b0, jalr: 1'b0, bne: 1'b0, alu_op: op, md_valid: 1'b0,
          md_op: 3'd0, alu_src: 1'b0, fwd_a: 2'b00, fwd_b: 2'b00, rs1: a, rs2: b,
          imm: 32'h10, pc: 32'h0000_1000, wb: 32'h0, mem: 32'h0, rd: 5'd3, flush: 1'b0};
    return s;
  endfunction

  function automatic stim_t md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    stim_t s;
    s = base(4'd0, a, b);
    s.md_valid = 1'b1;
    s.md_op    = op;
    s.rd       = 5'd9;
    return s;
  endfunction

  task automatic run_txn(input stim_t s);
    exp_t e;
    int   n, bad;
    @(negedge clk);
    apply(s);
    sb_q.push_back(model(s));
    #1;
    n   = 0;
    bad = 0;
    while (ex_stall && n < 200) begin
      n++;
      @(posedge clk);
      #1;
      if (ctl_out != 5'd0 || rd_out != 5'd0 || {jal_out, jalr_out, bne_out} != 3'd0) bad++;
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("stall_cycles", 32'(n), 32'(e.stalls));
    if (e.stalls > 0) check_eq("stall_bubble", 32'(bad), 32'd0);
    check_eq("ctl_out", 32'(ctl_out), 32'(e.ctl));
    check_eq("jmp_out", 32'({jal_out, jalr_out, bne_out}), 32'(e.jmp));
    check_eq("rd_out", 32'(rd_out), 32'(e.rd));
    if (e.data_valid) begin
      check_eq("alu_result", alu_result, e.res);
      check_eq("zero_out", 32'(zero_out), 32'(e.zero));
      check_eq("write_data", write_data, e.wdata);
      check_eq("pcimm_out", pcimm_out, e.pcimm);
      check_eq("pc_out", pc_out, e.pc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_alu"}, alu_result, 32'd0);
    check_eq({tag, "_ctl_rd"}, 32'({ctl_out, rd_out}), 32'd0);
    check_eq({tag, "_flags"}, 32'({jal_out, jalr_out, bne_out, zero_out}), 32'd0);
    check_eq({tag, "_pc"}, pc_out | pcimm_out | write_data, 32'd0);
  endtask

  stim_t s;

  initial begin
    reset = 1'b0;
    apply(base(4'd0, 32'd0, 32'd0));
    ctl_in = 5'd0;
    rd_in  = 5'd0;
    #12;
    check_all_zero("reset");
    check_eq("reset_stall", 32'(ex_stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ADD with immediate
    s = base(4'd0, 32'd5, 32'h1234);
    s.alu_src = 1'b1;
    s.imm     = 32'hFFFF_FFF9;
    s.ctl     = 5'b11010;
    s.jal     = 1'b1;
    run_txn(s);

    // SUB with both operands forwarded
    s = base(4'd1, 32'hDEAD, 32'hBEEF);
    s.fwd_a = 2'b10;
    s.mem   = 32'h10;
    s.fwd_b = 2'b01;
    s.wb    = 32'h10;
    s.bne   = 1'b1;
    run_txn(s);

    // fwd 11 falls back to register file; x0 destination passes through
    s = base(4'd4, 32'hF0F0_0000, 32'h0F0F_1234);
    s.fwd_a = 2'b11;
    s.fwd_b = 2'b11;
    s.rd    = 5'd0;
    run_txn(s);

    run_txn(base(4'd7, 32'h8000_0010, 32'h0000_0024));
    run_txn(base(4'd8, 32'hFFFF_FFFF, 32'd1));
    run_txn(base(4'd9, 32'hFFFF_FFFF, 32'd1));

    // flush kills control but not data capture
    s = base(4'd0, 32'd1, 32'd2);
    s.flush = 1'b1;
    s.jalr  = 1'b1;
    run_txn(s);

    run_txn(md(3'd4, 32'hFFFF_FFF9, 32'd2));
    run_txn(md(3'd5, 32'd7, 32'd0));
    run_txn(md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF));
    run_txn(md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF));
    run_txn(md(3'd6, 32'hFFFF_FFF9, 32'd0));
    run_txn(md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    run_txn(md(3'd2, 32'hFFFF_FFFE, 32'h8000_0000));
    run_txn(md(3'd1, 32'h8000_0000, 32'h8000_0000));
    run_txn(md(3'd0, 32'h0001_0003, 32'h0002_0005));

    if (MdEn) begin
      // flush at RUN cycle 10 aborts the divide
      @(negedge clk);
      apply(md(3'd4, 32'd100, 32'd7));
      repeat (11) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      check_eq("abort_stall", 32'(ex_stall), 32'd0);
      check_eq("abort_ctl_rd", 32'({ctl_out, rd_out}), 32'd0);
      run_txn(base(4'd2, 32'h0000_FF0F, 32'h0000_0FF0));
      run_txn(md(3'd7, 32'd100, 32'd7));
    end

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    s = md(3'd4, 32'd1000, 32'd3);
    s.pc = 32'h0000_2000;
    apply(s);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    md_valid = 1'b0;
    #1;
    check_eq("midreset_stall", 32'(ex_stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_txn(md(3'd4, 32'hFFFF_FC18, 32'd3));

    for (int i = 0; i < 24; i++) begin
      s = base(4'($urandom_range(0, 9)), $urandom, $urandom);
      if (i % 3 == 0) s.rs2 = $urandom_range(0, 40);
      s.ctl      = 5'($urandom);
      s.jal      = 1'($urandom);
      s.bne      = 1'($urandom);
      s.fwd_a    = 2'($urandom);
      s.fwd_b    = 2'($urandom);
      s.alu_src  = ($urandom_range(0, 3) == 0);
      s.imm      = $urandom;
      s.wb       = $urandom;
      s.mem      = $urandom;
      s.pc       = $urandom;
      s.rd       = 5'($urandom);
      s.flush    = ($urandom_range(0, 7) == 0);
      s.md_valid = !s.flush && ($urandom_range(0, 3) == 0);
      s.md_op    = 3'($urandom);
      run_txn(s);
    end

    @(negedge clk);
    apply(base(4'd0, 32'd0, 32'd0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
